// File: rtl/trdb_pkg.sv
// ----------------------------------------------------------------------------
// trdb_pkg
// Shared constants for the trace debugger branch-map logic.
//   BRANCH_MAP_DEPTH : default number of branch outcomes a map can hold
//                      (the E-Trace branch map limit).
//   NRET_DEFAULT     : default number of branch lanes retired per cycle.
// ----------------------------------------------------------------------------
package trdb_pkg;

    localparam int BRANCH_MAP_DEPTH = 31;
    localparam int NRET_DEFAULT     = 2;

endpackage

// File: rtl/trdb_branch_map_multi_if.sv
// ----------------------------------------------------------------------------
// trdb_branch_map_multi_if
// Bundles the branch-retire inputs and the map outputs of the branch map.
//   valid_i        : per-lane branch-retired strobe, lane 0 oldest
//   branch_taken_i : per-lane outcome, 1 = taken
//   flush_i        : map consumed by the packet emitter, clear it
//   map_o          : stored outcomes, bit 0 oldest, 1 = NOT taken
//   branches_o     : number of valid bits in map_o
//   is_full_o      : map holds DEPTH outcomes
//   is_empty_o     : map holds no outcomes
//   overflow_o     : one-cycle pulse, outcomes were dropped this update
//   dropped_o      : number of outcomes dropped in the pulsed cycle
// master drives the retire side, slave is the branch map itself.
// ----------------------------------------------------------------------------
interface trdb_branch_map_multi_if
    import trdb_pkg::*;
#(
    parameter int DEPTH = BRANCH_MAP_DEPTH,
    parameter int NRET  = NRET_DEFAULT
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = $clog2(NRET + 1);

    logic [NRET-1:0]  valid_i;
    logic [NRET-1:0]  branch_taken_i;
    logic             flush_i;
    logic [DEPTH-1:0] map_o;
    logic [CW-1:0]    branches_o;
    logic             is_full_o;
    logic             is_empty_o;
    logic             overflow_o;
    logic [KW-1:0]    dropped_o;

    modport master (
        output valid_i,
        output branch_taken_i,
        output flush_i,
        input  map_o,
        input  branches_o,
        input  is_full_o,
        input  is_empty_o,
        input  overflow_o,
        input  dropped_o
    );

    modport slave (
        input  valid_i,
        input  branch_taken_i,
        input  flush_i,
        output map_o,
        output branches_o,
        output is_full_o,
        output is_empty_o,
        output overflow_o,
        output dropped_o
    );

endinterface

// File: rtl/trdb_lane_compact.sv
// ----------------------------------------------------------------------------
// trdb_lane_compact
// Squeezes the valid retire lanes together in lane (program) order.
//   valid_i        : per-lane valid strobe
//   branch_taken_i : per-lane taken flag, ignored where valid_i is low
//   packed_taken_o : taken flags of valid lanes, packed from bit 0 upward;
//                    bits at or above count_o are 0
//   count_o        : number of valid lanes (k)
// Purely combinational.
// ----------------------------------------------------------------------------
module trdb_lane_compact
    import trdb_pkg::*;
#(
    parameter int NRET = NRET_DEFAULT,
    localparam int KW  = $clog2(NRET + 1)
) (
    input  logic [NRET-1:0] valid_i,
    input  logic [NRET-1:0] branch_taken_i,
    output logic [NRET-1:0] packed_taken_o,
    output logic [KW-1:0]   count_o
);

    // Each valid lane lands in the slot given by how many valid lanes
    // precede it; rank walks up as valid lanes are encountered, so lane
    // order is preserved without any variable-index writes.
    always_comb begin : compact
        int rank;
        rank           = 0;
        packed_taken_o = '0;
        for (int i = 0; i < NRET; i++) begin
            for (int j = 0; j < NRET; j++) begin
                if (valid_i[i] && (rank == j)) begin
                    packed_taken_o[j] = branch_taken_i[i];
                end
            end
            if (valid_i[i]) begin
                rank = rank + 1;
            end
        end
        count_o = KW'(rank);
    end

endmodule

// File: rtl/trdb_branch_map_multi.sv
// ----------------------------------------------------------------------------
// trdb_branch_map_multi
// Collects up to DEPTH branch outcomes, NRET lanes per cycle, into an
// E-Trace style branch map (1 = not taken, bit 0 oldest).
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous active-high reset, wins over flush and new lanes
//   bus   : slave side of trdb_branch_map_multi_if (retire lanes, flush,
//           map/count/full/empty/overflow/dropped outputs)
// Outcomes that do not fit are dropped (newest first) and reported through
// a registered overflow pulse aligned with the map update.
// ----------------------------------------------------------------------------
module trdb_branch_map_multi
    import trdb_pkg::*;
#(
    parameter int DEPTH = BRANCH_MAP_DEPTH,
    parameter int NRET  = NRET_DEFAULT,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int KW   = $clog2(NRET + 1)
) (
    input logic                     clk_i,
    input logic                     rst_i,
    trdb_branch_map_multi_if.slave  bus
);

    logic [DEPTH-1:0] map_q;
    logic [DEPTH-1:0] map_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [KW-1:0]    drop_q;
    logic [KW-1:0]    drop_d;

    logic [NRET-1:0]  packed_taken;
    logic [KW-1:0]    k;

    trdb_lane_compact #(
        .NRET (NRET)
    ) u_compact (
        .valid_i        (bus.valid_i),
        .branch_taken_i (bus.branch_taken_i),
        .packed_taken_o (packed_taken),
        .count_o        (k)
    );

    // Next map and count. A flush empties the map before the new outcomes
    // are appended, so a flush with valid lanes starts again at bit 0.
    // Only as many outcomes as there are free slots are accepted; the
    // packed vector is oldest-first, so the newest ones are the ones lost.
    // Accepted outcomes are masked, inverted to the not-taken encoding and
    // shifted up to the current fill level, keeping bits above the count 0.
    always_comb begin : next_state
        logic [DEPTH-1:0] base_map;
        logic [CW-1:0]    base_cnt;
        logic [NRET-1:0]  new_bits;
        int               free_slots;
        int               k_int;
        int               accept;

        base_map   = bus.flush_i ? '0 : map_q;
        base_cnt   = bus.flush_i ? '0 : cnt_q;
        free_slots = DEPTH - int'(base_cnt);
        k_int      = int'(k);
        accept     = (k_int > free_slots) ? free_slots : k_int;

        new_bits = '0;
        for (int i = 0; i < NRET; i++) begin
            if (i < accept) begin
                new_bits[i] = ~packed_taken[i];
            end
        end

        map_d  = base_map | (DEPTH'(new_bits) << base_cnt);
        cnt_d  = base_cnt + CW'(accept);
        drop_d = KW'(k_int - accept);
        ovf_d  = (k_int > accept);
    end

    // State register. Reset clears everything and discards any lanes
    // presented in the same cycle, so no overflow is reported for them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            map_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            map_q  <= map_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign bus.map_o      = map_q;
    assign bus.branches_o = cnt_q;
    assign bus.is_full_o  = (cnt_q == CW'(DEPTH));
    assign bus.is_empty_o = (cnt_q == '0);
    assign bus.overflow_o = ovf_q;
    assign bus.dropped_o  = drop_q;

endmodule

// File: tb/tb_trdb_branch_map_multi.sv
// ----------------------------------------------------------------------------
// tb_trdb_branch_map_multi
// Self-checking bench for trdb_branch_map_multi. Instance A uses the default
// geometry (DEPTH=31, NRET=2) for directed vectors and corner sequences;
// instance B (DEPTH=8, NRET=4) runs a long random stream against a model.
// ----------------------------------------------------------------------------
module tb_trdb_branch_map_multi;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    trdb_branch_map_multi_if #(.DEPTH(31), .NRET(2)) ifa ();
    trdb_branch_map_multi_if #(.DEPTH(8),  .NRET(4)) ifb ();

    trdb_branch_map_multi #(.DEPTH(31), .NRET(2)) dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (ifa.slave)
    );

    trdb_branch_map_multi #(.DEPTH(8), .NRET(4)) dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (ifb.slave)
    );

    typedef struct packed {
        logic [31:0] map;
        logic [7:0]  cnt;
        logic [7:0]  drop;
    } mstate_t;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [1:0]  valid;
        logic [1:0]  taken;
        logic [30:0] map;
        logic [4:0]  cnt;
        logic [1:0]  drop;
    } vec_t;

    mstate_t qa[$];
    mstate_t qb[$];
    mstate_t sa;
    mstate_t sb;
    vec_t    vecs[11];
    int      tests  = 0;
    int      failed = 0;

    // Reference behaviour: walk the lanes oldest first, append each valid
    // outcome while there is room, count the rest as dropped.
    function automatic mstate_t model_step(input mstate_t s, input int depth,
                                           input int nret, input logic r,
                                           input logic f, input logic [3:0] v,
                                           input logic [3:0] t);
        mstate_t n;
        n      = s;
        n.drop = '0;
        if (r || f) begin
            n.map = '0;
            n.cnt = '0;
        end
        if (!r) begin
            for (int i = 0; i < nret; i++) begin
                if (v[i]) begin
                    if (int'(n.cnt) < depth) begin
                        if (!t[i]) n.map = n.map | (32'd1 << n.cnt);
                        n.cnt = n.cnt + 8'd1;
                    end else begin
                        n.drop = n.drop + 8'd1;
                    end
                end
            end
        end
        return n;
    endfunction

    // One comparison: count it, report it if it is wrong.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pop the oldest expectation for instance A and compare every output.
    task automatic checkA();
        mstate_t e;
        if (qa.size() == 0) return;
        e = qa.pop_front();
        checkOutput("a_map",   32'(ifa.map_o),      e.map);
        checkOutput("a_count", 32'(ifa.branches_o), 32'(e.cnt));
        checkOutput("a_full",  32'(ifa.is_full_o),  32'(e.cnt == 8'd31));
        checkOutput("a_empty", 32'(ifa.is_empty_o), 32'(e.cnt == 8'd0));
        checkOutput("a_ovf",   32'(ifa.overflow_o), 32'(e.drop != 8'd0));
        checkOutput("a_drop",  32'(ifa.dropped_o),  32'(e.drop));
    endtask

    task automatic checkB();
        mstate_t e;
        if (qb.size() == 0) return;
        e = qb.pop_front();
        checkOutput("b_map",   32'(ifb.map_o),      e.map);
        checkOutput("b_count", 32'(ifb.branches_o), 32'(e.cnt));
        checkOutput("b_full",  32'(ifb.is_full_o),  32'(e.cnt == 8'd8));
        checkOutput("b_empty", 32'(ifb.is_empty_o), 32'(e.cnt == 8'd0));
        checkOutput("b_ovf",   32'(ifb.overflow_o), 32'(e.drop != 8'd0));
        checkOutput("b_drop",  32'(ifb.dropped_o),  32'(e.drop));
    endtask

    // Drive one cycle of stimulus on the falling edge, first checking the
    // result of the previous cycle, then queueing the expected result.
    task automatic applyStimulusA(input logic r, input logic f,
                                  input logic [1:0] v, input logic [1:0] t,
                                  input mstate_t e);
        @(negedge clk);
        checkA();
        rst_a              = r;
        ifa.flush_i        = f;
        ifa.valid_i        = v;
        ifa.branch_taken_i = t;
        qa.push_back(e);
    endtask

    task automatic stepA(input logic r, input logic f,
                         input logic [1:0] v, input logic [1:0] t);
        sa = model_step(sa, 31, 2, r, f, {2'b00, v}, {2'b00, t});
        applyStimulusA(r, f, v, t, sa);
    endtask

    task automatic stepB(input logic r, input logic f,
                         input logic [3:0] v, input logic [3:0] t);
        sb = model_step(sb, 8, 4, r, f, v, t);
        @(negedge clk);
        checkB();
        rst_b              = r;
        ifb.flush_i        = f;
        ifb.valid_i        = v;
        ifb.branch_taken_i = t;
        qb.push_back(sb);
    endtask

    initial begin
        mstate_t e;

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.flush_i = 1'b0; ifa.valid_i = '0; ifa.branch_taken_i = '0;
        ifb.flush_i = 1'b0; ifb.valid_i = '0; ifb.branch_taken_i = '0;
        sa = '0;
        sb = '0;

        // rst, flush, valid, taken -> map, count, dropped
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 31'h00, 5'd0, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 2'b11, 2'b01, 31'h02, 5'd2, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 2'b00, 31'h00, 5'd0, 2'd0};
        vecs[3]  = '{1'b0, 1'b0, 2'b10, 2'b00, 31'h01, 5'd1, 2'd0};
        vecs[4]  = '{1'b0, 1'b0, 2'b01, 2'b00, 31'h03, 5'd2, 2'd0};
        vecs[5]  = '{1'b0, 1'b0, 2'b11, 2'b11, 31'h03, 5'd4, 2'd0};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 2'b00, 31'h03, 5'd4, 2'd0};
        vecs[7]  = '{1'b0, 1'b0, 2'b10, 2'b10, 31'h03, 5'd5, 2'd0};
        vecs[8]  = '{1'b0, 1'b0, 2'b01, 2'b10, 31'h23, 5'd6, 2'd0};
        vecs[9]  = '{1'b0, 1'b1, 2'b11, 2'b00, 31'h03, 5'd2, 2'd0};
        vecs[10] = '{1'b1, 1'b0, 2'b11, 2'b11, 31'h00, 5'd0, 2'd0};

        for (int i = 0; i < 11; i++) begin
            e.map  = 32'(vecs[i].map);
            e.cnt  = 8'(vecs[i].cnt);
            e.drop = 8'(vecs[i].drop);
            applyStimulusA(vecs[i].rst, vecs[i].flush, vecs[i].valid,
                           vecs[i].taken, e);
        end
        sa = '0;

        // Fill to 30, then one more pair: only lane 0 fits at bit 30.
        for (int i = 0; i < 15; i++) stepA(1'b0, 1'b0, 2'b11, 2'(i));
        stepA(1'b0, 1'b0, 2'b11, 2'b10);
        stepA(1'b0, 1'b0, 2'b00, 2'b00);
        checkOutput("a_bit30_lane0", 32'(ifa.map_o[30]), 32'd1);
        checkOutput("a_fill_count",  32'(ifa.branches_o), 32'd31);
        checkOutput("a_fill_drop",   32'(ifa.dropped_o), 32'd1);

        // Full: everything dropped, map held.
        stepA(1'b0, 1'b0, 2'b11, 2'b00);
        stepA(1'b0, 1'b0, 2'b01, 2'b11);

        // Flush at full with both lanes valid: restart from bit 0.
        stepA(1'b0, 1'b1, 2'b11, 2'b10);
        stepA(1'b0, 1'b0, 2'b00, 2'b00);
        checkOutput("a_flush_map",   32'(ifa.map_o), 32'd1);
        checkOutput("a_flush_count", 32'(ifa.branches_o), 32'd2);
        checkOutput("a_flush_ovf",   32'(ifa.overflow_o), 32'd0);

        // Reach 10 entries, then reset with both lanes valid.
        for (int i = 0; i < 4; i++) stepA(1'b0, 1'b0, 2'b11, 2'(i + 1));
        stepA(1'b1, 1'b0, 2'b11, 2'b00);
        stepA(1'b0, 1'b0, 2'b00, 2'b00);
        checkOutput("a_rst_count", 32'(ifa.branches_o), 32'd0);
        checkOutput("a_rst_ovf",   32'(ifa.overflow_o), 32'd0);
        @(negedge clk);
        checkA();

        // Long random stream on the small instance.
        stepB(1'b1, 1'b0, 4'h0, 4'h0);
        for (int c = 0; c < 10000; c++) begin
            stepB(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                  4'($urandom), 4'($urandom));
        end
        @(negedge clk);
        checkB();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
